// File: rtl/serial_tx.sv
// Buffered LSB-first UART transmitter: start, 8 data, optional parity, 1-2 stop bits.
// Latency: a byte written to an empty, unblocked idle transmitter drives the start bit one edge later.
// Backpressure: busy (registered) reports a full FIFO; writes while full are dropped with a one-cycle overflow pulse.
//
// Ports:
//   clk      - system clock, all logic on rising edge
//   rst      - asynchronous active-low reset; forces tx high immediately
//   data     - byte to enqueue, sampled when new_data = 1
//   new_data - one-cycle write strobe
//   block    - 1 holds off the start of a new frame (sampled only at frame start)
//   busy     - 1 = FIFO full, producer must not strobe
//   overflow - one-cycle pulse per dropped write
//   tx       - serial output, idles high
module serial_tx #(
  parameter int CLK_PER_BIT = 50,
  parameter int FIFO_DEPTH  = 4,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       new_data,
  input  logic       block,
  output logic       busy,
  output logic       overflow,
  output logic       tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLK_PER_BIT);

  // Unsupported framing options are rejected at elaboration.
  generate
    if (PARITY > 2 || PARITY < 0 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
      $error("serial_tx: unsupported PARITY or STOP_BITS value");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_n;
  logic [7:0]    head;
  logic          wr_en;
  logic          pop;
  logic          can_pop;

  // Transmit engine
  state_t        state;
  state_t        state_n;
  logic [BW-1:0] baud;
  logic [BW-1:0] baud_n;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_n;
  logic [7:0]    shift;
  logic [7:0]    shift_n;
  logic          par_bit;
  logic          par_n;
  logic          tx_n;
  logic          baud_end;
  logic          stop_last;

  assign head      = mem[rd_ptr];
  assign can_pop   = (count != '0) && !block;
  assign baud_end  = (baud == BW'(CLK_PER_BIT - 1));
  assign stop_last = (bit_cnt == 3'(STOP_BITS - 1));

  // A write into a full FIFO still succeeds when the head leaves on the same edge.
  assign wr_en = new_data && ((count != CW'(FIFO_DEPTH)) || pop);

  always_comb begin
    count_n = count;
    case ({wr_en, pop})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
  end

  // Next-state logic. bit_cnt doubles as the stop-bit counter in S_STOP.
  always_comb begin
    state_n = state;
    baud_n  = baud + BW'(1);
    bit_n   = bit_cnt;
    shift_n = shift;
    par_n   = par_bit;
    pop     = 1'b0;

    case (state)
      S_IDLE: begin
        baud_n = '0;
        bit_n  = '0;
        if (can_pop) begin
          pop     = 1'b1;
          state_n = S_START;
        end
      end

      S_START: begin
        if (baud_end) begin
          state_n = S_DATA;
          baud_n  = '0;
          bit_n   = '0;
        end
      end

      S_DATA: begin
        if (baud_end) begin
          baud_n = '0;
          if (bit_cnt == 3'd7) begin
            bit_n   = '0;
            state_n = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_n   = bit_cnt + 3'd1;
            shift_n = {1'b0, shift[7:1]};
          end
        end
      end

      S_PARITY: begin
        if (baud_end) begin
          state_n = S_STOP;
          baud_n  = '0;
          bit_n   = '0;
        end
      end

      S_STOP: begin
        if (baud_end) begin
          baud_n = '0;
          if (stop_last) begin
            bit_n = '0;
            // Chain straight into the next start bit so bursts leave no idle gap.
            if (can_pop) begin
              pop     = 1'b1;
              state_n = S_START;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            bit_n = bit_cnt + 3'd1;
          end
        end
      end

      default: begin
        state_n = S_IDLE;
        baud_n  = '0;
        bit_n   = '0;
      end
    endcase

    // Parity is captured with the byte so the data shift can destroy it.
    if (pop) begin
      shift_n = head;
      par_n   = (^head) ^ (PARITY == 2);
    end
  end

  // tx is decoded from the next state and registered so the line is glitch-free.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shift_n[0];
      S_PARITY: tx_n = par_n;
      default:  tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      baud     <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      baud     <= baud_n;
      bit_cnt  <= bit_n;
      shift    <= shift_n;
      par_bit  <= par_n;
      tx       <= tx_n;
      count    <= count_n;
      busy     <= (count_n == CW'(FIFO_DEPTH));
      overflow <= new_data && !wr_en;
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= data;
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: latency, framing, parity, burst/overflow, flow control,
// asynchronous reset and FIFO wrap-around. Three instances cover the framing variants.
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       block;
  logic       nd0, nd1, nd2;
  logic       busy0, busy1, busy2;
  logic       ovf0, ovf1, ovf2;
  logic       tx0, tx1, tx2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_tx #(.CLK_PER_BIT(4), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .data(data), .new_data(nd0), .block(block),
    .busy(busy0), .overflow(ovf0), .tx(tx0));

  serial_tx #(.CLK_PER_BIT(4), .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .data(data), .new_data(nd1), .block(block),
    .busy(busy1), .overflow(ovf1), .tx(tx1));

  serial_tx #(.CLK_PER_BIT(4), .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst(rst), .data(data), .new_data(nd2), .block(block),
    .busy(busy2), .overflow(ovf2), .tx(tx2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic tx_of(input int sel);
    case (sel)
      0:       return tx0;
      1:       return tx1;
      default: return tx2;
    endcase
  endfunction

  // Expected line level for cycle c of a frame (4 clocks per bit): start, data LSB first, then high.
  function automatic logic exp_bit(input logic [7:0] b, input int c);
    int idx;
    logic [7:0] v;
    idx = c / 4;
    v   = b;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return v[idx-1];
    return 1'b1;
  endfunction

  // Checks cycles first..last of a frame; the caller stands on the negedge of cycle 'first'.
  task automatic check_frame(input int sel, input logic [7:0] b, input int first, input int last,
                             input string tag);
    for (int c = first; c <= last; c++) begin
      if (c != first) @(negedge clk);
      chk($sformatf("%s_c%0d", tag, c), 32'(tx_of(sel)), 32'(exp_bit(b, c)));
    end
  endtask

  // Watchdog: never hang.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b0;
    data  = 8'h00;
    block = 1'b0;
    nd0 = 1'b0; nd1 = 1'b0; nd2 = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    chk("rst_tx0", 32'(tx0), 32'd1);
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_ovf0", 32'(ovf0), 32'd0);
    chk("rst_tx1", 32'(tx1), 32'd1);
    chk("rst_tx2", 32'(tx2), 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_tx0", 32'(tx0), 32'd1);

    // ---------------- single byte 0x55, latency and length ----------------
    data = 8'h55; nd0 = 1'b1;
    @(negedge clk);                       // after E: stored, line still idle
    nd0 = 1'b0;
    chk("b55_lat_idle", 32'(tx0), 32'd1);
    @(negedge clk);                       // after E+1: start bit
    check_frame(0, 8'h55, 0, 39, "b55");
    repeat (4) begin
      @(negedge clk);
      chk("b55_after", 32'(tx0), 32'd1);
    end

    // ---------------- even parity, 2 stop bits: 0x07 then 0x03 back-to-back ----------------
    data = 8'h07; nd1 = 1'b1;
    @(negedge clk);
    data = 8'h03;
    chk("p1_lat_idle", 32'(tx1), 32'd1);
    @(negedge clk);
    nd1 = 1'b0;
    check_frame(1, 8'h07, 0, 35, "p1_07");
    for (int c = 36; c <= 47; c++) begin   // parity 1 (three ones), then 8 stop cycles
      @(negedge clk);
      chk($sformatf("p1_07_tail_c%0d", c), 32'(tx1), 32'd1);
    end
    @(negedge clk);                       // second start exactly 48 cycles after the first
    check_frame(1, 8'h03, 0, 35, "p1_03");
    for (int c = 36; c <= 39; c++) begin   // two ones -> even parity bit 0
      @(negedge clk);
      chk($sformatf("p1_03_par_c%0d", c), 32'(tx1), 32'd0);
    end
    for (int c = 40; c <= 49; c++) begin
      @(negedge clk);
      chk($sformatf("p1_03_stop_c%0d", c), 32'(tx1), 32'd1);
    end

    // ---------------- odd parity: 0x07 ----------------
    data = 8'h07; nd2 = 1'b1;
    @(negedge clk);
    nd2 = 1'b0;
    @(negedge clk);
    check_frame(2, 8'h07, 0, 35, "p2_07");
    for (int c = 36; c <= 39; c++) begin
      @(negedge clk);
      chk($sformatf("p2_07_par_c%0d", c), 32'(tx2), 32'd0);
    end
    for (int c = 40; c <= 45; c++) begin
      @(negedge clk);
      chk($sformatf("p2_07_stop_c%0d", c), 32'(tx2), 32'd1);
    end

    // ---------------- burst 0x41..0x46 ----------------
    for (int i = 0; i < 6; i++) begin
      data = 8'h41 + 8'(i);
      nd0  = 1'b1;
      @(negedge clk);                     // after E_i
      chk($sformatf("burst_busy_%0d", i), 32'(busy0), (i >= 4) ? 32'd1 : 32'd0);
      chk($sformatf("burst_ovf_%0d", i), 32'(ovf0), (i == 5) ? 32'd1 : 32'd0);
      chk($sformatf("burst_tx_%0d", i), 32'(tx0), (i == 0 || i == 5) ? 32'd1 : 32'd0);
    end
    nd0 = 1'b0;
    @(negedge clk);                       // after E6: frame 0x41 cycle 5
    chk("burst_ovf_end", 32'(ovf0), 32'd0);
    chk("burst_busy_hold", 32'(busy0), 32'd1);
    check_frame(0, 8'h41, 5, 39, "burst41");
    chk("burst_busy_last", 32'(busy0), 32'd1);
    for (int b = 8'h42; b <= 8'h45; b++) begin
      @(negedge clk);
      if (b == 8'h42) chk("burst_busy_fall", 32'(busy0), 32'd0);
      check_frame(0, 8'(b), 0, 39, $sformatf("burst%0h", b));
    end
    repeat (6) begin
      @(negedge clk);
      chk("burst_drained", 32'(tx0), 32'd1);
    end

    // ---------------- flow control ----------------
    block = 1'b1;
    data = 8'h31; nd0 = 1'b1;
    @(negedge clk);
    nd0 = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("blk_hold31", 32'(tx0), 32'd1);
    end
    block = 1'b0;
    @(negedge clk);
    check_frame(0, 8'h31, 0, 19, "blk31a");
    block = 1'b1;
    data = 8'h32; nd0 = 1'b1;
    @(negedge clk);
    nd0 = 1'b0;
    check_frame(0, 8'h31, 20, 39, "blk31b");
    repeat (8) begin
      @(negedge clk);
      chk("blk_hold32", 32'(tx0), 32'd1);
    end
    block = 1'b0;
    @(negedge clk);
    check_frame(0, 8'h32, 0, 39, "blk32");
    @(negedge clk);
    chk("blk_idle", 32'(tx0), 32'd1);

    // ---------------- reset mid-frame ----------------
    for (int i = 0; i < 5; i++) begin
      data = 8'hA1 + 8'(i);
      nd0  = 1'b1;
      @(negedge clk);
    end
    nd0 = 1'b0;
    chk("rstm_busy_full", 32'(busy0), 32'd1);   // frame 0xA1 is at cycle 3
    repeat (14) @(negedge clk);                 // cycle 17: data bit 3 of 0xA1 = 0
    chk("rstm_bit3", 32'(tx0), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("rstm_tx_async", 32'(tx0), 32'd1);
    chk("rstm_busy_async", 32'(busy0), 32'd0);
    chk("rstm_ovf_async", 32'(ovf0), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstm_tx_rel", 32'(tx0), 32'd1);
    data = 8'h5A; nd0 = 1'b1;
    @(negedge clk);
    nd0 = 1'b0;
    chk("rstm_lat_idle", 32'(tx0), 32'd1);
    @(negedge clk);
    check_frame(0, 8'h5A, 0, 39, "rstm5a");
    repeat (50) begin
      @(negedge clk);
      chk("rstm_no_stale", 32'(tx0), 32'd1);
    end

    // ---------------- wrap-around: 12 counter bytes as busy allows ----------------
    begin
      int n_wr;
      logic ovf_seen;
      n_wr = 0;
      ovf_seen = 1'b0;
      fork
        begin : writer
          for (int g = 0; g < 3000 && n_wr < 12; g++) begin
            if (!busy0) begin
              data = 8'h80 + 8'(n_wr);
              nd0  = 1'b1;
              n_wr++;
            end else begin
              nd0 = 1'b0;
            end
            @(negedge clk);
            if (ovf0) ovf_seen = 1'b1;
          end
          nd0 = 1'b0;
        end
        begin : receiver
          for (int j = 0; j < 12; j++) begin
            logic [7:0] rx;
            logic found;
            found = 1'b0;
            rx = 8'h00;
            for (int w = 0; w < 400 && !found; w++) begin
              @(negedge clk);
              if (tx0 == 1'b0) found = 1'b1;
            end
            chk($sformatf("wrap_start_%0d", j), 32'(found), 32'd1);
            if (!found) break;
            for (int c = 1; c <= 39; c++) begin
              @(negedge clk);
              for (int i = 0; i < 8; i++) begin
                if (c == 6 + 4 * i) rx[i] = tx0;
              end
              if (c == 38) chk($sformatf("wrap_stop_%0d", j), 32'(tx0), 32'd1);
            end
            chk($sformatf("wrap_byte_%0d", j), 32'(rx), 32'(8'h80 + 8'(j)));
          end
        end
      join
      chk("wrap_written", 32'(n_wr), 32'd12);
      chk("wrap_no_ovf", 32'(ovf_seen), 32'd0);
      repeat (10) begin
        @(negedge clk);
        chk("wrap_idle", 32'(tx0), 32'd1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
